// File: rtl/axil_write_ctrl.sv
// axil_write_ctrl: single-outstanding AXI-Lite write sequencer driving AW/W stage handshakes, collecting B with a timeout guard
module axil_write_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strb,
  output logic        aw_start,
  output logic [31:0] aw_addr,
  input  logic        aw_comp,
  output logic        w_start,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  input  logic        w_comp,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        done,
  output logic [1:0]  resp,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        aw_ok, w_ok, aw_hit, w_hit, expired;
  assign aw_hit  = aw_ok | (aw_start & aw_comp);
  assign w_hit   = w_ok | (w_start & w_comp);
  assign expired = cnt >= 16'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      aw_ok     <= 1'b0;
      w_ok      <= 1'b0;
      req_ready <= 1'b0;
      aw_start  <= 1'b0;
      aw_addr   <= '0;
      w_start   <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      bready    <= 1'b0;
      done      <= 1'b0;
      resp      <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req_ready && req_valid) begin
            state     <= ISSUE;
            req_ready <= 1'b0;
            aw_addr   <= req_addr & ~32'h3;
            w_data    <= req_data;
            w_strb    <= req_strb;
            aw_start  <= 1'b1;
            w_start   <= 1'b1;
            aw_ok     <= 1'b0;
            w_ok      <= 1'b0;
            cnt       <= '0;
          end else begin
            req_ready <= 1'b1;
          end
        ISSUE: begin
          cnt <= cnt + 16'd1;
          if (aw_start && aw_comp) begin
            aw_start <= 1'b0;
            aw_ok    <= 1'b1;
          end
          if (w_start && w_comp) begin
            w_start <= 1'b0;
            w_ok    <= 1'b1;
          end
          if (aw_hit && w_hit) begin
            state  <= RESP;
            bready <= 1'b1;
          end else if (expired) begin
            state    <= DONE;
            aw_start <= 1'b0;
            w_start  <= 1'b0;
            done     <= 1'b1;
            resp     <= 2'b10;
            timeout  <= 1'b1;
          end
        end
        RESP: begin
          cnt <= cnt + 16'd1;
          if (bvalid) begin
            state   <= DONE;
            bready  <= 1'b0;
            done    <= 1'b1;
            resp    <= bresp;
            timeout <= 1'b0;
          end else if (expired) begin
            state   <= DONE;
            bready  <= 1'b0;
            done    <= 1'b1;
            resp    <= 2'b10;
            timeout <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/axil_write_ctrl.md
Name: axil_write_ctrl

Overview:
Upstream sequencer for one AXI-Lite write master. It accepts a single write request over a valid/ready interface and drives the start/comp handshakes of the AW-channel and W-channel stages. It then collects the B response directly from the bus and reports one completion per request, with a timeout guard. Only one transaction is in flight at a time; the block sits between the register/command front-end and the per-channel stages.

Parameters:
TIMEOUT, 256, cycles allowed from request acceptance to B handshake before abort (legal range 2..65535)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request available
req_ready  out  1  block can accept request (high only in IDLE)
req_addr  in  32  byte address of the write
req_data  in  32  write data
req_strb  in  4  byte strobes
aw_start  out  1  start to AW-channel stage
aw_addr  out  32  address to AW-channel stage
aw_comp  in  1  AW-channel handshake done (held high while aw_start high)
w_start  out  1  start to W-channel stage
w_data  out  32  data to W-channel stage
w_strb  out  4  strobes to W-channel stage
w_comp  in  1  W-channel handshake done (held high while w_start high)
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
bresp  in  2  AXI B response
done  out  1  one-cycle completion pulse
resp  out  2  response of the completed write, valid while done=1
timeout  out  1  with done: transaction aborted by timeout

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-transaction: state=IDLE and every output 0 (req_ready, aw_start, aw_addr, w_start, w_data, w_strb, bready, done, resp, timeout). The timeout counter and the aw_ok/w_ok flags clear. The first req_ready=1 appears on the first clock edge after reset deasserts.
- States: IDLE, ISSUE, RESP, DONE.
- IDLE: req_ready=1. On req_valid=1 at an edge, the block captures the request and moves to ISSUE:
  - aw_addr = {req_addr[31:2], 2'b00}
  - w_data = req_data; w_strb = req_strb
  - aw_start=1, w_start=1 from the next cycle
  - counter cleared to 0
- ISSUE: aw_start stays high until aw_comp is sampled 1. On that edge aw_start goes to 0 and sticky aw_ok is set; w_start/w_ok behave the same way. Both comps may arrive in the same cycle or in either order. When aw_ok and w_ok are both set (including sets on the current edge), go to RESP. aw_addr/w_data/w_strb hold their values until the next accept.
- RESP: bready=1. On bvalid=1 at an edge: resp=bresp, timeout=0, go to DONE, bready drops on that edge. bvalid before RESP is not consumed because bready=0.
- DONE: done=1 for exactly one cycle with resp/timeout valid, then IDLE. req_ready=0 in DONE, so back-to-back requests have a minimum spacing of one idle cycle.
- Timeout: the counter increments on every cycle spent in ISSUE or RESP. If counter==TIMEOUT-1 at an edge and the state's exit condition is not met, go to DONE with resp=2'b10 and timeout=1; aw_start, w_start and bready all go 0.
- A real completion on the same edge as expiry wins (normal path, timeout=0).
- resp and timeout hold their last values outside DONE. Only done qualifies them.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic write: req addr=0x0000_1003, data=0xDEAD_BEEF, strb=4'hF. aw_comp and w_comp at ISSUE cycle 2, bvalid with bresp=00 two cycles into RESP -> aw_addr=0x0000_1000, w_data=0xDEAD_BEEF, done=1 for one cycle, resp=00, timeout=0, req_ready=1 the next cycle.
- Skewed comps: aw_comp at ISSUE cycle 1, w_comp at cycle 5 -> aw_start low from cycle 2, w_start low after cycle 5, bready rises one cycle after w_comp, and never earlier.
- Early bvalid plus error response: bvalid=1 with bresp=2'b10 held from ISSUE entry -> bready=0 until RESP; then a one-cycle handshake, done with resp=10.
- Timeout: TIMEOUT=8, aw_comp never asserted -> done with timeout=1 and resp=10 exactly 8 cycles after entering ISSUE; aw_start and w_start are 0 afterwards.
- Tie case: TIMEOUT=8, bvalid arrives on the expiry edge -> done with resp=bresp and timeout=0.
- Reset mid-RESP: assert reset asynchronously between edges -> all outputs 0 immediately, without waiting for a clock. After release, a new request completes normally with no stale aw_ok/w_ok.
